rv32i_mem_stage: RTL
====================

RV32I_MEM_STAGE -- requirements
Module: rv32i_mem_stage

Interface
REQ-001 Parameter NUM_IO, default 2: number of IO channels, 1..4.
REQ-002 Parameter IO_SEL_BIT, default 31: alu_in bit that selects IO (1) or RAM (0).
REQ-003 Parameter IO_CH_LSB, default 16: LSB of the channel-index field in alu_in; width is clog2(NUM_IO), minimum 1.
REQ-004 Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute-stage instruction valid.
- in_ready  out  1  stage can accept.
- pc_in, iw_in, alu_in, rs2_data_in  in  32 each  from execute stage.
- wb_en_in  in  1  writeback enable; wb_reg_in  in  5  destination register.
- mem_req  out  1  RAM request; mem_we  out  1  write enable; mem_be  out  4  byte enables.
- mem_addr  out  30  word address; mem_wdata  out  32  write data.
- mem_ack  in  1  RAM completion; mem_rdata  in  32  RAM read data.
- io_req  out  NUM_IO  one-hot IO request; io_we  out  1; io_be  out  4; io_addr  out  30; io_wdata  out  32.
- io_ack  in  NUM_IO  per-channel completion; io_rdata  in  32*NUM_IO  channel n at [32n+31:32n].
- out_valid  out  1  writeback-stage valid; pc_out, iw_out  out  32 each; wb_en_out  out  1; wb_reg_out  out  5; wb_data_out  out  32.
- df_mem_enable  out  1; df_mem_reg  out  5; df_mem_data  out  32  forwarding.
- misalign_trap  out  1  misaligned-access flag.

Function
REQ-005 Load is iw_in[6:0]=0000011 and store is 0100011; width is funct3 = iw_in[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 FSM states are IDLE and ACCESS; in_ready SHALL be 1 only in IDLE.
REQ-007 In IDLE with in_valid, a non-load/store SHALL produce out_valid=1 on the next cycle, with wb_data_out=alu_in and the other outputs taken from the inputs.
REQ-008 In IDLE with in_valid, a load or store SHALL register its request fields and enter ACCESS; the request is asserted from the next cycle.
REQ-009 In ACCESS:
- alu_in[IO_SEL_BIT]=0: mem_req=1.
- alu_in[IO_SEL_BIT]=1: io_req bit ch=1, where ch is the IO_CH_LSB field.
- addr, we, be and wdata SHALL be held stable until the matching ack.
REQ-010 Channel index >= NUM_IO SHALL complete in 1 cycle, with no io_req and read data 0.
REQ-011 On ack, FSM returns to IDLE and out_valid=1 on the next cycle; the request drops in the ack cycle's successor; ack arriving in the first request cycle gives minimum 2-cycle latency.
REQ-012 Store byte enables:
- B: be = 0001<<addr[1:0], wdata = byte replicated x4.
- H: be = 0011<<addr[1:0], wdata = halfword replicated x2.
- W: be = 1111.
REQ-013 Loads SHALL extract the byte or halfword at addr[1:0] from the read data, sign-extend for B/H and zero-extend for BU/HU, and place the result on wb_data_out.
REQ-014 Stores SHALL force wb_en_out=0.
REQ-015 Acks arriving in IDLE, or on an unselected channel, SHALL be ignored.
REQ-016 Forwarding outputs:
- df_mem_enable SHALL equal out_valid & wb_en_out.
- df_mem_reg = wb_reg_out.
- df_mem_data = wb_data_out.
REQ-017 out_valid SHALL be a single-cycle pulse per accepted instruction.

Reset
REQ-018 Reset SHALL force IDLE and zero all registered outputs (out_valid, pc_out, iw_out, wb_en_out, wb_reg_out, wb_data_out, misalign_trap) and all request/strobe outputs.
REQ-019 Reset during ACCESS SHALL abort the access: request deasserted next cycle, no out_valid, and a later ack ignored.

Configuration
REQ-020 Macro RV32I_MEM_MISALIGN_TRAP_EN controls misaligned accesses (H with addr[0]=1, or W with addr[1:0]!=0).
REQ-021 With RV32I_MEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL:
- issue no request;
- produce out_valid next cycle with misalign_trap=1 and wb_en_out=0.
REQ-022 With RV32I_MEM_MISALIGN_TRAP_EN undefined, misalign_trap SHALL be tied to 0 and the low address bits that cause misalignment are cleared (H: bit0, W: bits1:0) before access.

Verification
REQ-023 SW, alu_in=0x00000104, rs2=0xDEADBEEF, mem_ack one cycle after mem_req -> mem_addr=0x41, mem_be=1111, mem_wdata=0xDEADBEEF, wb_en_out=0.
REQ-024 LB, alu_in=0x00000203, mem_rdata=0x80FFFFFF -> wb_data_out=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-025 SH, alu_in=0x80010002 with NUM_IO=2 -> io_req=10, io_be=1100, io_wdata = halfword x2; ack held off 3 cycles -> in_ready=0 throughout and out_valid one cycle after io_ack.
REQ-026 ADD (opcode 0110011), alu_in=0x12 -> out_valid next cycle, wb_data_out=0x12, df_mem_enable=1, no requests.
REQ-027 LW, alu_in=0x00000006 -> with the macro: misalign_trap=1, no mem_req; without: mem_addr=0x1 and a normal load.
REQ-028 Reset asserted in the second ACCESS cycle of an LW, followed by mem_ack -> mem_req=0 after reset and out_valid stays 0.

Source files
------------

// File: rtl/rv32i_mem_stage.sv
// rv32i_mem_stage: RV32I memory stage steering loads/stores to RAM or one of NUM_IO IO channels.
// Define RV32I_MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module rv32i_mem_stage #(
  parameter int NUM_IO     = 2,
  parameter int IO_SEL_BIT = 31,
  parameter int IO_CH_LSB  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            iw_in,
  input  logic [31:0]            alu_in,
  input  logic [31:0]            rs2_data_in,
  input  logic                   wb_en_in,
  input  logic [4:0]             wb_reg_in,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [29:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic [NUM_IO-1:0]      io_req,
  output logic                   io_we,
  output logic [3:0]             io_be,
  output logic [29:0]            io_addr,
  output logic [31:0]            io_wdata,
  input  logic [NUM_IO-1:0]      io_ack,
  input  logic [32*NUM_IO-1:0]   io_rdata,
  output logic                   out_valid,
  output logic [31:0]            pc_out,
  output logic [31:0]            iw_out,
  output logic                   wb_en_out,
  output logic [4:0]             wb_reg_out,
  output logic [31:0]            wb_data_out,
  output logic                   df_mem_enable,
  output logic [4:0]             df_mem_reg,
  output logic [31:0]            df_mem_data,
  output logic                   misalign_trap
);
  localparam int CW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [2:0] f3, acc_f3;
  logic is_ld, is_st, half, word, trap, ch_bad_in, acc_io, acc_ch_bad, acc_we, ack_io, done;
  logic [31:0] ea, wd_in, acc_wdata, rd_io, rdata, sh, ld;
  logic [3:0] be_in, acc_be;
  logic [CW-1:0] ch_in, acc_ch;
  logic [29:0] acc_addr;
  logic [1:0] acc_lo;
  assign in_ready = state == IDLE;
  assign mem_we = acc_we;
  assign mem_be = acc_be;
  assign mem_addr = acc_addr;
  assign mem_wdata = acc_wdata;
  assign io_we = acc_we;
  assign io_be = acc_be;
  assign io_addr = acc_addr;
  assign io_wdata = acc_wdata;
  assign df_mem_enable = out_valid & wb_en_out;
  assign df_mem_reg = wb_reg_out;
  assign df_mem_data = wb_data_out;
  always_comb begin
    f3 = iw_in[14:12];
    is_ld = iw_in[6:0] == 7'b0000011;
    is_st = iw_in[6:0] == 7'b0100011;
    half = f3[1:0] == 2'b01;
    word = f3[1];
`ifdef RV32I_MEM_MISALIGN_TRAP_EN
    trap = (is_ld | is_st) & ((half & alu_in[0]) | (word & |alu_in[1:0]));
    ea = alu_in;
`else
    trap = 1'b0;
    ea = {alu_in[31:2], alu_in[1] & ~word, alu_in[0] & ~half & ~word};
`endif
    ch_in = alu_in[IO_CH_LSB +: CW];
    ch_bad_in = 32'(ch_in) >= NUM_IO;
    be_in = word ? 4'b1111 : half ? 4'b0011 << ea[1:0] : 4'b0001 << ea[1:0];
    wd_in = word ? rs2_data_in : half ? {2{rs2_data_in[15:0]}} : {4{rs2_data_in[7:0]}};
  end
  // Out-of-range channels match no slot, so they read as zero and complete at once.
  always_comb begin
    ack_io = 1'b0;
    rd_io = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (32'(acc_ch) == i) begin
        ack_io = io_ack[i];
        rd_io = io_rdata[32*i +: 32];
      end
    done = acc_io ? (acc_ch_bad | ack_io) : mem_ack;
    rdata = acc_io ? rd_io : mem_rdata;
    sh = rdata >> {acc_lo, 3'b000};
    ld = acc_f3[1] ? sh : acc_f3[0] ? {{16{~acc_f3[2] & sh[15]}}, sh[15:0]} : {{24{~acc_f3[2] & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      pc_out <= '0;
      iw_out <= '0;
      wb_en_out <= 1'b0;
      wb_reg_out <= '0;
      wb_data_out <= '0;
      misalign_trap <= 1'b0;
      mem_req <= 1'b0;
      io_req <= '0;
      acc_we <= 1'b0;
      acc_be <= '0;
      acc_addr <= '0;
      acc_wdata <= '0;
      acc_io <= 1'b0;
      acc_ch <= '0;
      acc_ch_bad <= 1'b0;
      acc_f3 <= '0;
      acc_lo <= '0;
    end else begin
      out_valid <= 1'b0;
      misalign_trap <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          pc_out <= pc_in;
          iw_out <= iw_in;
          wb_reg_out <= wb_reg_in;
          wb_en_out <= wb_en_in & ~is_st & ~trap;
          wb_data_out <= alu_in;
          if ((is_ld | is_st) & ~trap) begin
            state <= ACCESS;
            mem_req <= ~alu_in[IO_SEL_BIT];
            io_req <= (alu_in[IO_SEL_BIT] & ~ch_bad_in) ? NUM_IO'(1) << ch_in : '0;
            acc_we <= is_st;
            acc_be <= be_in;
            acc_addr <= ea[31:2];
            acc_wdata <= wd_in;
            acc_io <= alu_in[IO_SEL_BIT];
            acc_ch <= ch_in;
            acc_ch_bad <= ch_bad_in;
            acc_f3 <= f3;
            acc_lo <= ea[1:0];
          end else begin
            out_valid <= 1'b1;
            misalign_trap <= trap;
          end
        end
      end else if (done) begin
        state <= IDLE;
        mem_req <= 1'b0;
        io_req <= '0;
        out_valid <= 1'b1;
        wb_data_out <= acc_we ? 32'h0 : ld;
      end
    end
  end
endmodule
